// File: rtl/muldiv_sequencer.sv
// HI/LO sequencer for multi-cycle MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Define MULDIV_DIVZERO_BYPASS_EN to send divide-by-zero straight to DONE with HI/LO untouched.
module muldiv_sequencer #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_signed,
    input  logic [63:0] mul_prod,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_busy,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);

    // state     | meaning
    // IDLE      | accept new op; MTHI/MTLO complete here
    // MUL_WAIT  | counting down multiplier latency
    // DIV_START | one-cycle start pulse to the divider
    // DIV_WAIT  | waiting for divider to drop busy
    // DONE      | result visible, CPU advances on the next edge
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MUL_WAIT  = 3'd1,
        S_DIV_START = 3'd2,
        S_DIV_WAIT  = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;

    logic is_mul;
    logic is_div;
    logic is_mthi;
    logic is_mtlo;
    logic div_bypass;

    assign is_mul  = op_valid && (op == OP_MULT || op == OP_MULTU);
    assign is_div  = op_valid && (op == OP_DIV  || op == OP_DIVU);
    assign is_mthi = op_valid && (op == OP_MTHI);
    assign is_mtlo = op_valid && (op == OP_MTLO);

`ifdef MULDIV_DIVZERO_BYPASS_EN
    assign div_bypass = is_div && (rt_data == 32'd0);
`else
    assign div_bypass = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (is_mul) begin
                    state_next = S_MUL_WAIT;
                end else if (is_div) begin
                    state_next = div_bypass ? S_DONE : S_DIV_START;
                end
            end
            S_MUL_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = S_DONE;
                end
            end
            S_DIV_START: state_next = S_DIV_WAIT;
            S_DIV_WAIT: begin
                if (!div_busy) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // div_start decodes state directly so an async reset drops it at once
    always_comb begin
        stall     = 1'b0;
        div_start = 1'b0;
        unique case (state)
            S_IDLE:      stall = is_mul || is_div;
            S_MUL_WAIT:  stall = 1'b1;
            S_DIV_START: begin
                stall     = 1'b1;
                div_start = 1'b1;
            end
            S_DIV_WAIT:  stall = 1'b1;
            S_DONE:      stall = 1'b0;
            default:     stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a      <= 32'd0;
            mul_b      <= 32'd0;
            mul_signed <= 1'b0;
            div_a      <= 32'd0;
            div_b      <= 32'd0;
            div_signed <= 1'b0;
            cnt        <= 4'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (is_mul) begin
                        mul_a      <= rs_data;
                        mul_b      <= rt_data;
                        mul_signed <= (op == OP_MULT);
                        cnt        <= CNT_LOAD;
                    end
                    if (is_div && !div_bypass) begin
                        div_a      <= rs_data;
                        div_b      <= rt_data;
                        div_signed <= (op == OP_DIV);
                    end
                    if (is_mthi) begin
                        hi <= rs_data;
                    end
                    if (is_mtlo) begin
                        lo <= rs_data;
                    end
                end
                S_MUL_WAIT: begin
                    if (cnt == 4'd0) begin
                        hi <= mul_prod[63:32];
                        lo <= mul_prod[31:0];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DIV_WAIT: begin
                    if (!div_busy) begin
                        lo <= div_q;
                        hi <= div_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: vector table, reset-abort sequences, random ops vs a reference model.
// Follows MULDIV_DIVZERO_BYPASS_EN so expectations match whichever build is compiled.
module tb_muldiv_sequencer;

    localparam int LAT = 2;

`ifdef MULDIV_DIVZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data;
    logic [31:0] mul_a, mul_b;
    logic        mul_signed;
    logic [63:0] mul_prod;
    logic        div_start, div_signed;
    logic [31:0] div_a, div_b;
    logic        div_busy;
    logic [31:0] div_q, div_r;
    logic [31:0] hi, lo;
    logic        stall;

    int total = 0;
    int bad   = 0;
    int busy_len = 1;

    muldiv_sequencer #(.MUL_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed), .mul_prod(mul_prod),
        .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
        .div_busy(div_busy), .div_q(div_q), .div_r(div_r),
        .hi(hi), .lo(lo), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mul64(logic [31:0] a, logic [31:0] b, logic sgn);
        if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
        return {32'd0, a} * {32'd0, b};
    endfunction

    // returns {remainder, quotient}; x/0 gives all-ones quotient, remainder = dividend
    function automatic logic [63:0] div64(logic [31:0] a, logic [31:0] b, logic sgn);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // external unit models: combinational multiplier, divider busy for busy_len cycles incl. start
    assign mul_prod = mul64(mul_a, mul_b, mul_signed);

    logic [5:0]  bcnt;
    logic [31:0] dq, dr;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt <= 6'd0;
            dq   <= 32'd0;
            dr   <= 32'd0;
        end else if (div_start) begin
            bcnt     <= 6'(busy_len - 1);
            {dr, dq} <= div64(div_a, div_b, div_signed);
        end else if (bcnt != 6'd0) begin
            bcnt <= bcnt - 6'd1;
        end
    end
    assign div_busy = div_start | (bcnt != 6'd0);
    assign div_q    = dq;
    assign div_r    = dr;

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Issues one op from IDLE, scribbles random ops while busy, returns stall/div_start counts and HI/LO.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int nb, output int st, output int ps,
                          output logic [31:0] h, output logic [31:0] l);
        int  guard;
        bit  fin;
        busy_len = nb;
        @(negedge clk);
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        #1;
        st = int'(stall);
        ps = int'(div_start);
        @(posedge clk);
        #1;
        if (o <= 3'd3) begin
            guard = 0;
            fin   = 1'b0;
            while (!fin) begin
                op_valid = 1'($urandom_range(0, 1));
                op       = 3'($urandom_range(0, 7));
                rs_data  = $urandom;
                rt_data  = $urandom;
                #1;
                if (stall) st++;
                if (div_start) ps++;
                if (!stall) fin = 1'b1;
                @(posedge clk);
                #1;
                guard++;
                if (!fin && guard > 200) begin
                    total++;
                    bad++;
                    $display("FAIL op_timeout: stall still high after %0d cycles, required done", guard);
                    fin = 1'b1;
                end
            end
        end
        op_valid = 1'b0;
        #1;
        h = hi;
        l = lo;
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a, b;
        int          nb;
        logic [31:0] eh, el;
        int          est, eps;
    } vec_t;

    vec_t vt[10];

    initial begin
        int st, ps, est, eps;
        logic [31:0] h, l, rh, rl, a, b;
        logic [2:0] o;
        logic [63:0] p;
        int nb;

        clk = 0; reset = 1; op_valid = 0; op = 0; rs_data = 0; rt_data = 0;

        vt[0] = '{3'd4, 32'h12345678, 32'h0, 1, 32'h12345678, 32'h0, 0, 0};
        vt[1] = '{3'd0, 32'hFFFFFFFE, 32'h3, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, LAT + 1, 0};
        vt[2] = '{3'd3, 32'd100, 32'd7, 32, 32'd2, 32'd14, 34, 1};
        vt[3] = '{3'd5, 32'hA5A5A5A5, 32'h0, 1, 32'd2, 32'hA5A5A5A5, 0, 0};
        vt[4] = '{3'd6, 32'hDEADBEEF, 32'h1, 1, 32'd2, 32'hA5A5A5A5, 0, 0};
        vt[5] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, LAT + 1, 0};
        vt[6] = '{3'd2, 32'hFFFFFFF9, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFD, 7, 1};
`ifdef MULDIV_DIVZERO_BYPASS_EN
        vt[7] = '{3'd2, 32'h00001234, 32'h0, 3, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 0};
`else
        vt[7] = '{3'd2, 32'h00001234, 32'h0, 3, 32'h00001234, 32'hFFFFFFFF, 5, 1};
`endif
        vt[8] = '{3'd0, 32'h80000000, 32'd2, 1, 32'hFFFFFFFF, 32'h00000000, LAT + 1, 0};
        vt[9] = '{3'd4, 32'h0, 32'h0, 1, 32'h0, 32'h0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        check_w("rst0_hi", hi, 32'h0);
        check_w("rst0_lo", lo, 32'h0);
        check_i("rst0_stall", int'(stall), 0);
        @(negedge clk);
        reset = 0;

        foreach (vt[i]) begin
            run_op(vt[i].o, vt[i].a, vt[i].b, vt[i].nb, st, ps, h, l);
            check_w($sformatf("vec%0d_hi", i), h, vt[i].eh);
            check_w($sformatf("vec%0d_lo", i), l, vt[i].el);
            check_i($sformatf("vec%0d_stall", i), st, vt[i].est);
            check_i($sformatf("vec%0d_divstart", i), ps, vt[i].eps);
        end

        // reset while DIV_START drives the pulse
        run_op(3'd4, 32'hCAFEF00D, 32'h0, 1, st, ps, h, l);
        check_w("pre_hi", h, 32'hCAFEF00D);
        run_op(3'd5, 32'h0BADBEEF, 32'h0, 1, st, ps, h, l);
        check_w("pre_lo", l, 32'h0BADBEEF);
        @(negedge clk);
        busy_len = 20; op_valid = 1; op = 3'd2; rs_data = 32'd50; rt_data = 32'd5;
        @(posedge clk);
        #1;
        op_valid = 0;
        check_i("div_start_on", int'(div_start), 1);
        @(negedge clk);
        reset = 1;
        #1;
        check_i("rst_div_start_async", int'(div_start), 0);
        check_i("rst_stall", int'(stall), 0);
        check_w("rst_hi", hi, 32'h0);
        check_w("rst_lo", lo, 32'h0);
        check_w("rst_mul_a", mul_a, 32'h0);
        check_w("rst_mul_b", mul_b, 32'h0);
        check_w("rst_div_a", div_a, 32'h0);
        check_w("rst_div_b", div_b, 32'h0);
        check_i("rst_modes", int'({mul_signed, div_signed}), 0);
        @(negedge clk);
        reset = 0;

        // reset in DIV_WAIT, with an MTHI offered meanwhile that must be ignored
        run_op(3'd4, 32'h11111111, 32'h0, 1, st, ps, h, l);
        run_op(3'd5, 32'h22222222, 32'h0, 1, st, ps, h, l);
        @(negedge clk);
        busy_len = 20; op_valid = 1; op = 3'd3; rs_data = 32'd1000; rt_data = 32'd3;
        @(posedge clk);
        #1;
        op = 3'd4; rs_data = 32'hFFFF0000;
        repeat (4) @(posedge clk);
        #1;
        check_i("divwait_stall", int'(stall), 1);
        check_w("divwait_hi_held", hi, 32'h11111111);
        @(negedge clk);
        reset = 1; op_valid = 0;
        #1;
        check_i("rst_wait_stall", int'(stall), 0);
        check_w("rst_wait_hi", hi, 32'h0);
        check_w("rst_wait_lo", lo, 32'h0);
        @(negedge clk);
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        check_w("post_rst_hi", hi, 32'h0);
        check_w("post_rst_lo", lo, 32'h0);

        // random ops against the reference model; HI/LO start at 0 after the reset above
        rh = 32'h0;
        rl = 32'h0;
        for (int k = 0; k < 40; k++) begin
            o  = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            nb = $urandom_range(1, 6);
            est = 0;
            eps = 0;
            case (o)
                3'd0, 3'd1: begin
                    p   = mul64(a, b, o == 3'd0);
                    rh  = p[63:32];
                    rl  = p[31:0];
                    est = LAT + 1;
                end
                3'd2, 3'd3: begin
                    if (BYPASS && b == 32'h0) begin
                        est = 1;
                    end else begin
                        p   = div64(a, b, o == 3'd2);
                        rh  = p[63:32];
                        rl  = p[31:0];
                        est = 2 + nb;
                        eps = 1;
                    end
                end
                3'd4: rh = a;
                3'd5: rl = a;
                default: begin
                end
            endcase
            run_op(o, a, b, nb, st, ps, h, l);
            check_w($sformatf("rnd%0d_op%0d_hi", k, o), h, rh);
            check_w($sformatf("rnd%0d_op%0d_lo", k, o), l, rl);
            check_i($sformatf("rnd%0d_op%0d_stall", k, o), st, est);
            check_i($sformatf("rnd%0d_op%0d_divstart", k, o), ps, eps);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check_w($sformatf("rnd%0d_hold_hi", k), hi, rh);
            check_w($sformatf("rnd%0d_hold_lo", k), lo, rl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
